ucode_store_loader: RTL

Writable control store plus loader for the microprogrammed multicycle controller. It accepts a byte stream over a valid/ready handshake and assembles 17-bit microwords. It writes them into a 32-entry store and verifies a trailing XOR checksum. The sequencer reads the store asynchronously via rd_addr/rd_data, the same way it reads the fixed ROM, and hold_cpu keeps the core stalled until a verified image is resident.

---
 rtl/ucode_pkg.sv | 34 +++
 rtl/ucode_ram.sv | 24 ++
 rtl/ucode_store_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/ucode_pkg.sv
// Shared constants, loader state encoding and control-word field map for the
// writable microcode store.
package ucode_pkg;

    localparam int UWORD_W        = 17;
    localparam int UDEPTH         = 32;
    localparam int UADDR_W        = 5;
    localparam int BYTES_PER_WORD = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_CHK  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;

    // Bit positions of the control lines inside a microword.
    localparam int F_NEXTPC       = 16;
    localparam int F_REGW         = 15;
    localparam int F_MEMW         = 14;
    localparam int F_IRWRITE      = 13;
    localparam int F_ADRSRC       = 12;
    localparam int F_RESULTSRC_HI = 11;
    localparam int F_RESULTSRC_LO = 10;
    localparam int F_SRCA         = 9;
    localparam int F_SRCB_HI      = 8;
    localparam int F_SRCB_LO      = 7;
    localparam int F_ALUOP        = 6;
    localparam int F_BRANCH       = 5;
    localparam int F_NEXTADDR_HI  = 4;
    localparam int F_NEXTADDR_LO  = 0;

endpackage

// File: rtl/ucode_ram.sv
// Control store array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so an image survives a core reset.
module ucode_ram
    import ucode_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [UADDR_W-1:0] waddr,
    input  logic [UWORD_W-1:0] wdata,
    input  logic [UADDR_W-1:0] raddr,
    output logic [UWORD_W-1:0] rdata
);

    logic [UWORD_W-1:0] mem [UDEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ucode_store_loader.sv
// Byte-stream loader for the writable control store: assembles 3-byte microwords,
// writes them in order and releases the core only after the XOR checksum matches.
module ucode_store_loader
    import ucode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic [UADDR_W-1:0] rd_addr,
    output logic [UWORD_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               chk_err,
    output logic               hold_cpu,
    output logic [UADDR_W:0]   wr_count,
    output logic [2:0]         dbg_state
);

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on state, never on in_valid.

    loader_state_e      state_q, state_d;
    logic [UADDR_W:0]   wr_count_q, wr_count_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic               ram_we;
    logic [UWORD_W-1:0] ram_wdata;

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        ram_we     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d    = ST_RECV;
                    wr_count_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                end
            end
            ST_RECV: begin
                if (in_valid) begin
                    csum_d = csum_q ^ in_data;
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        ram_we     = 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                        byte_idx_d = '0;
                        if (wr_count_q == (UADDR_W + 1)'(UDEPTH - 1)) begin
                            state_d = ST_CHK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == 2'd0) begin
                            b0_d = in_data;
                        end else begin
                            b1_d = in_data;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (in_valid) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_count_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
        end
    end

    // Only bit 0 of the third byte reaches the word; the rest is reserved.
    assign ram_wdata = {in_data[0], b1_q, b0_q};

    ucode_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_count_q[UADDR_W-1:0]),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign in_ready  = (state_q == ST_RECV) || (state_q == ST_CHK);
    assign busy      = in_ready;
    assign done      = (state_q == ST_DONE);
    assign chk_err   = (state_q == ST_ERR);
    assign hold_cpu  = (state_q != ST_DONE);
    assign wr_count  = wr_count_q;
    assign dbg_state = state_q;

endmodule
